mod_mul_pipe: RTL
=================

// Module: mod_mul_pipe
// PURPOSE
//  Pipelined, multi-lane modular multiplier: c = a*b mod q, q chosen per beat
//  (Kyber q=3329 or Dilithium q=8380417). Successor to the combinational
//  multiplier; sits between the PE operand fetch and the butterfly/accumulate
//  stages. Registered stages, valid/ready handshake with backpressure, tag
//  sideband and flush.
// PARAMETERS
//  LANES   1   independent multiplier lanes sharing one handshake and mode
//  STAGES  3   pipeline depth = latency in cycles; legal range 2..6
//  TAG_W   4   width of the opaque tag carried alongside each beat
// PORTS
//  clk_i        in   1          clock, all logic on rising edge
//  rst_ni       in   1          asynchronous active-low reset
//  flush_i      in   1          sync clear: drop every in-flight beat
//  in_valid_i   in   1          input beat valid
//  in_ready_o   out  1          pipe can accept a beat this cycle
//  select_i     in   1          0 = Kyber (q=3329), 1 = Dilithium (q=8380417)
//  a_i, b_i     in   LANES*23   operands; lane k = bits [23k+22:23k]
//  tag_i        in   TAG_W      sideband, returned unchanged with result
//  out_valid_o  out  1          result beat valid
//  out_ready_i  in   1          consumer accepts result
//  c_o          out  LANES*23   results, same lane packing as a_i
//  tag_o        out  TAG_W      tag of the beat on c_o
//  busy_o       out  1          at least one stage holds a valid beat
// BEHAVIOUR
//  - Reset (rst_ni=0, async): all stage valids, out_valid_o, c_o, tag_o,
//    busy_o = 0. Data regs may also be cleared; valids are mandatory.
//  - Transfer in: in_valid_i & in_ready_o. Out: out_valid_o & out_ready_i.
//  - Global stall: en = !out_valid_o | out_ready_i; in_ready_o = en
//    (combinational). en=0 freezes every stage; nothing lost or duplicated.
//  - Latency: beat accepted at edge t appears on c_o/tag_o after edge t+STAGES-1
//    when en held 1; throughput 1 beat/cycle with out_ready_i=1.
//  - Bubbles propagate; out_valid_o/c_o/tag_o stable while stalled.
//  - Arithmetic, per lane, exact mod result for all inputs in contract:
//    Kyber: only a[11:0], b[11:0] used (0..4095), upper bits ignored;
//      c = (a*b) mod 3329, zero-extended to 23 bits, c[22:12]=0.
//    Dilithium: full 23-bit a,b (0..2^23-1), 46-bit product;
//      c = (a*b) mod 8380417. Always 0 <= c < q, no lazy reduction.
//  - select_i and tag_i captured with the beat; mixed modes may be
//    back-to-back with no penalty, each beat uses its own select.
//  - flush_i=1: at next edge all stage valids clear, out_valid_o=0;
//    in_ready_o held 0 while flush_i=1; beat offered that cycle not accepted.
//    flush_i dominates out_ready_i.
//  - busy_o = OR of all stage valids (incl. output stage).
//  - Reset mid-operation: all beats discarded immediately, no partial output.
// TESTING
//  1 Kyber LANES=1: a=1234,b=2345 -> c=829 after STAGES cycles; a=3328,
//    b=3328 -> 1; a=4095,b=4095 -> 852; a=0xFFF000+5,b=7 -> 35 (upper ignored).
//  2 Dilithium: a=8380416,b=8380416 -> 1; a=4190209,b=2 -> 1;
//    a=8388607,b=8388607 -> golden model value, c<8380417.
//  3 Streaming 1000 random beats, mixed select_i, random tags, out_ready_i
//    random 50% -> in-order, tags match, no drop/dup, each c = golden.
//  4 Stall: fill pipe, out_ready_i=0 for 10 cycles -> in_ready_o=0 once
//    out_valid_o=1, c_o/tag_o stable; release -> STAGES beats drain in order.
//  5 Flush with pipe full and out_ready_i=0 -> next cycle out_valid_o=0,
//    busy_o=0; following beat returns with correct latency.
//  6 LANES=4: distinct operands per lane, select=1 -> each lane independent;
//    assert rst_ni low mid-stream -> outputs 0 asynchronously, clean restart.

Source files
------------

// File: rtl/mod_mul_pipe.sv
// mod_mul_pipe: pipelined multi-lane modular multiplier, c = a*b mod q with q = 3329
// or 8380417 chosen per beat. It has a valid/ready stall, a tag sideband and a synchronous flush.
module mod_mul_pipe #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  select_i,
  input  logic [LANES*23-1:0]   a_i,
  input  logic [LANES*23-1:0]   b_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES*23-1:0]   c_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  busy_o
);

  localparam int unsigned W  = 23;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned DW = LANES * W;
  localparam logic [23:0] Q_DIL = 24'd8380417;
  localparam logic [23:0] Q_KYB = 24'd3329;
  localparam logic [36:0] M_KYB = 37'd5039;  // floor(2^24 / 3329)

  // 2^23 == 2^13 - 1 (mod 8380417). Folding the high part three times leaves a value below 2q.
  function automatic logic [W-1:0] reduce_dil(input logic [PW-1:0] x);
    logic [36:0] y;
    logic [27:0] z;
    logic [23:0] u;
    y = {1'b0, x[45:23], 13'd0} + {14'd0, x[22:0]} - {14'd0, x[45:23]};
    z = {1'b0, y[36:23], 13'd0} + {5'd0, y[22:0]} - {14'd0, y[36:23]};
    u = {6'd0, z[27:23], 13'd0} + {1'b0, z[22:0]} - {19'd0, z[27:23]};
    if (u >= Q_DIL) u = u - Q_DIL;
    return u[W-1:0];
  endfunction

  // Barrett reduction with k=24. The quotient estimate is low by at most one, so one subtract is enough.
  function automatic logic [11:0] reduce_kyb(input logic [23:0] x);
    logic [12:0] q_est;
    logic [23:0] r;
    q_est = 13'(({13'd0, x} * M_KYB) >> 24);
    r     = x - {11'd0, q_est} * Q_KYB;
    if (r >= Q_KYB) r = r - Q_KYB;
    return r[11:0];
  endfunction

  logic                en;
  logic [STAGES-1:0]   vld_q, vld_d;
  logic [LANES*PW-1:0] prod_q, prod_d;
  logic                sel_q;
  logic [DW-1:0]       red_d;
  logic [DW-1:0]       res_q [1:STAGES-1];
  logic [TAG_W-1:0]    tag_q [STAGES];

  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en && !flush_i;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    prod_d = '0;
    red_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [PW-1:0] a_ext, b_ext;
      if (select_i) begin
        a_ext = PW'(a_i[l*W +: W]);
        b_ext = PW'(b_i[l*W +: W]);
      end else begin
        a_ext = PW'(a_i[l*W +: 12]);
        b_ext = PW'(b_i[l*W +: 12]);
      end
      prod_d[l*PW +: PW] = a_ext * b_ext;
      if (sel_q) red_d[l*W +: W] = reduce_dil(prod_q[l*PW +: PW]);
      else       red_d[l*W +: W] = {11'd0, reduce_kyb(prod_q[l*PW +: 24])};
    end
  end

  always_comb begin
    vld_d = vld_q;
    if (flush_i) vld_d = '0;
    else if (en) vld_d = {vld_q[STAGES-2:0], in_valid_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: data registers are reset as well as valids, so c_o and tag_o read zero out of reset.
      vld_q  <= '0;
      prod_q <= '0;
      sel_q  <= 1'b0;
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
      for (int s = 1; s < STAGES; s++) res_q[s] <= '0;
    end else begin
      vld_q <= vld_d;
      if (en) begin
        prod_q   <= prod_d;
        sel_q    <= select_i;
        tag_q[0] <= tag_i;
        res_q[1] <= red_d;
        for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
        for (int s = 2; s < STAGES; s++) res_q[s] <= res_q[s-1];
      end
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign c_o         = res_q[STAGES-1];
  assign tag_o       = tag_q[STAGES-1];
  assign busy_o      = |vld_q;

endmodule
